// File: rtl/mult.sv
// mult: pipelined 64x64 -> 64 unsigned multiplier (low half of the product).
// NUM_STAGE registered stages (1, 2, 4, 8, 16, 32 or 64). Each stage folds one
// 64/NUM_STAGE-bit multiplier chunk into the running partial product, LSB
// chunk first. A new operation may start every cycle; results leave in issue
// order, each flagged by a one-cycle done pulse.
// Optional build macro MULT_OUTPUT_REG_EN adds one output register on
// product/done (latency NUM_STAGE+1). Default build: latency NUM_STAGE.
module mult #(
  parameter int NUM_STAGE = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] mcand,
  input  logic [63:0] mplier,
  input  logic        start,
  output logic [63:0] product,
  output logic        done
);

  // Multiplier bits consumed per stage.
  localparam int CW = 64 / NUM_STAGE;

  // One done bit per stage; bit s is the done bit registered by stage s.
  logic [NUM_STAGE-1:0] vld_pipe;

  // Done bits ride alongside the data; start=0 shifts in a 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= start;
      for (int s = 1; s < NUM_STAGE; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Stage i sees the multiplier with i chunks already consumed, so only the
  // remaining RI bits are carried forward; the shifted multiplicand is kept
  // full width because the product is truncated to 64 bits anyway.
  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    localparam int RI = 64 - i * CW;

    logic [63:0]   pp_in;
    logic [63:0]   mc_in;
    logic [RI-1:0] mp_in;
    logic [63:0]   pp_q;

    if (i == 0) begin : g_head
      assign pp_in = '0;
      assign mc_in = mcand;
      assign mp_in = mplier;
    end else begin : g_link
      assign pp_in = g_stage[i-1].pp_q;
      assign mc_in = g_stage[i-1].g_fwd.mc_q;
      assign mp_in = g_stage[i-1].g_fwd.mp_q;
    end

    // Accumulate this stage's chunk; partial products advance even when
    // idle, consumers qualify with done.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) pp_q <= '0;
      else       pp_q <= pp_in + mc_in * 64'(mp_in[CW-1:0]);
    end

    // The last stage has no downstream consumer of the shifted operands.
    if (i < NUM_STAGE - 1) begin : g_fwd
      logic [63:0]      mc_q;
      logic [RI-CW-1:0] mp_q;

      // Shift multiplicand up and drop the consumed multiplier chunk.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          mc_q <= '0;
          mp_q <= '0;
        end else begin
          mc_q <= mc_in << CW;
          mp_q <= mp_in[RI-1:CW];
        end
      end
    end
  end

`ifdef MULT_OUTPUT_REG_EN
  // Extra retiming register on the result; resets to 0 like the stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      product <= '0;
      done    <= 1'b0;
    end else begin
      product <= g_stage[NUM_STAGE-1].pp_q;
      done    <= vld_pipe[NUM_STAGE-1];
    end
  end
`else
  assign product = g_stage[NUM_STAGE-1].pp_q;
  assign done    = vld_pipe[NUM_STAGE-1];
`endif

endmodule

// File: tb/tb_mult.sv
// tb_mult: drives three mult instances (NUM_STAGE 8, 1, 64) with shared
// stimulus. A scoreboard queue per instance holds {due cycle, product}; every
// negedge each instance's done/product is compared against it.
module tb_mult;

`ifdef MULT_OUTPUT_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  localparam int ND = 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [63:0]            mcand, mplier;
  logic                   start;
  logic [ND-1:0][63:0]    prod;
  logic [ND-1:0]          dn;

  mult #(.NUM_STAGE(8))  u_m8  (.clock(clock), .reset(reset), .mcand(mcand), .mplier(mplier),
                                .start(start), .product(prod[0]), .done(dn[0]));
  mult #(.NUM_STAGE(1))  u_m1  (.clock(clock), .reset(reset), .mcand(mcand), .mplier(mplier),
                                .start(start), .product(prod[1]), .done(dn[1]));
  mult #(.NUM_STAGE(64)) u_m64 (.clock(clock), .reset(reset), .mcand(mcand), .mplier(mplier),
                                .start(start), .product(prod[2]), .done(dn[2]));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat(int d);
    case (d)
      0:       return 8 + XL;
      1:       return 1 + XL;
      default: return 64 + XL;
    endcase
  endfunction

  typedef struct {
    int          due;
    logic [63:0] p;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
  } vec_t;

  exp_t q [ND][$];
  vec_t tbl [10];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present a start in the current slot; it is sampled at the next posedge.
  task automatic issue_now(input logic [63:0] a, input logic [63:0] b, input logic [63:0] p);
    exp_t e;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    for (int d = 0; d < ND; d++) begin
      e.due = cyc + lat(d);
      e.p   = p;
      q[d].push_back(e);
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] p);
    @(posedge clock); #1;
    issue_now(a, b, p);
  endtask

  // Idle slots wiggle the operands to show they are ignored without start.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      start  = 1'b0;
      mcand  = {$urandom, $urandom};
      mplier = {$urandom, $urandom};
    end
  endtask

  // Per-cycle scoreboard check for every instance.
  initial begin
    forever begin
      @(negedge clock);
      for (int d = 0; d < ND; d++) begin
        if (q[d].size() > 0 && q[d][0].due == cyc) begin
          chk($sformatf("done_pulse[%0d]", d), 64'(dn[d]), 64'd1);
          chk($sformatf("product[%0d]", d), prod[d], q[d][0].p);
          void'(q[d].pop_front());
        end else begin
          chk($sformatf("done_idle[%0d]", d), 64'(dn[d]), 64'd0);
        end
      end
    end
  end

  initial begin
    logic [63:0] a, b;
    tbl[0] = '{64'd3, 64'd5, 64'd15};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
    tbl[2] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'h0};
    tbl[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[4] = '{64'd2, 64'd2, 64'd4};
    tbl[5] = '{64'd7, 64'd9, 64'd63};
    tbl[6] = '{64'd0, 64'hDEAD_BEEF_1234_5678, 64'd0};
    tbl[7] = '{64'd100, 64'd100, 64'd10000};
    tbl[8] = '{64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000};
    tbl[9] = '{64'h1234_5678, 64'h10, 64'h1_2345_6780};

    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_product[%0d]", d), prod[d], 64'd0);
      chk($sformatf("reset_done[%0d]", d), 64'(dn[d]), 64'd0);
    end
    // First edge after deassertion must accept a start.
    reset = 1'b0;
    issue_now(64'd3, 64'd5, 64'd15);
    idle(70);

    // Isolated single operation, then the table back-to-back.
    issue(64'd3, 64'd5, 64'd15);
    idle(70);
    for (int i = 0; i < 10; i++) issue(tbl[i].a, tbl[i].b, tbl[i].p);
    idle(70);

    // Asynchronous reset with operations in flight.
    issue(64'd11, 64'd13, 64'd143);
    issue(64'd17, 64'd19, 64'd323);
    idle(2);
    @(posedge clock); #2;
    reset = 1'b1;
    for (int d = 0; d < ND; d++) q[d].delete();
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("async_rst_product[%0d]", d), prod[d], 64'd0);
      chk($sformatf("async_rst_done[%0d]", d), 64'(dn[d]), 64'd0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    issue_now(64'd6, 64'd7, 64'd42);
    idle(70);

    // Random traffic against the arithmetic reference.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) a = a & 64'hFFFF;
        if ($urandom_range(0, 2) == 0) b = b & 64'hFFFF_FFFF;
        issue(a, b, a * b);
      end else begin
        idle(1);
      end
    end
    idle(70);

    for (int d = 0; d < ND; d++)
      chk($sformatf("pending_left[%0d]", d), 64'(q[d].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
